// File: rtl/prefix_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prefix_pkg: shared scan-mode type and width-generic saturating adder
// Rev 1.0
// ----------------------------------------------------------------------------
package prefix_pkg;

  typedef enum logic {
    INCL = 1'b0,
    EXCL = 1'b1
  } scan_mode_e;

  localparam int unsigned c_ADD_MAX_W = 64;
  localparam logic [c_ADD_MAX_W:0] c_ONE = {{c_ADD_MAX_W{1'b0}}, 1'b1};

  // Adds two width-bit values held zero-extended in c_ADD_MAX_W bits; ovf flags a
  // true sum above 2^width-1, and the result either wraps or clamps.
  function automatic logic [c_ADD_MAX_W-1:0] sat_add(
    input  logic [c_ADD_MAX_W-1:0] a,
    input  logic [c_ADD_MAX_W-1:0] b,
    input  int unsigned            width,
    input  logic                   sat,
    output logic                   ovf
  );
    logic [c_ADD_MAX_W:0] full;
    logic [c_ADD_MAX_W:0] lim;
    full = {1'b0, a} + {1'b0, b};
    lim  = (c_ONE << width) - c_ONE;
    ovf  = (full > lim);
    if (!ovf) begin
      sat_add = full[c_ADD_MAX_W-1:0];
    end else if (sat) begin
      sat_add = lim[c_ADD_MAX_W-1:0];
    end else begin
      sat_add = full[c_ADD_MAX_W-1:0] & lim[c_ADD_MAX_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/prefix_scan_comb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prefix_scan_comb: combinational inclusive scan across the lanes of one beat
// Rev 1.0
// ----------------------------------------------------------------------------
module prefix_scan_comb
  import prefix_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LANES    = 4,
  parameter int SATURATE = 0
) (
  input  logic [LANES*WIDTH-1:0] i_data,
  output logic [LANES*WIDTH-1:0] o_part,
  output logic [WIDTH-1:0]       o_total,
  output logic                   o_ovf
);

  logic [WIDTH-1:0] w_acc [LANES];
  logic [LANES-1:0] w_ovf;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_acc[i] = '0;
      w_ovf[i] = 1'b0;
    end
    w_acc[0] = i_data[WIDTH-1:0];
    for (int i = 1; i < LANES; i++) begin
      w_acc[i] = WIDTH'(sat_add(c_ADD_MAX_W'(w_acc[i-1]),
                                c_ADD_MAX_W'(i_data[i*WIDTH +: WIDTH]),
                                WIDTH, (SATURATE != 0), w_ovf[i]));
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_pack
    assign o_part[i*WIDTH +: WIDTH] = w_acc[i];
  end

  assign o_total = w_acc[LANES-1];
  assign o_ovf   = |w_ovf;

endmodule
`default_nettype wire

// File: rtl/prefix_scan_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prefix_scan_pipe: two-stage segmented prefix-sum pipeline with valid/ready
// Rev 1.0
// ----------------------------------------------------------------------------
module prefix_scan_pipe
  import prefix_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LANES    = 4,
  parameter int SATURATE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   IN_valid,
  output logic                   IN_ready,
  input  logic [LANES*WIDTH-1:0] IN_data,
  input  logic                   IN_last,
  input  logic                   IN_excl,
  input  logic                   IN_clear,
  output logic                   OUT_valid,
  input  logic                   OUT_ready,
  output logic [LANES*WIDTH-1:0] OUT_data,
  output logic                   OUT_last,
  output logic                   OUT_ovf
);

  logic                   r_s1_valid;
  logic [LANES*WIDTH-1:0] r_s1_part;
  logic [WIDTH-1:0]       r_s1_total;
  logic                   r_s1_ovf;
  logic                   r_s1_last;
  scan_mode_e             r_s1_mode;

  logic                   r_out_valid;
  logic [LANES*WIDTH-1:0] r_out_data;
  logic                   r_out_last;
  logic                   r_out_ovf;
  logic [WIDTH-1:0]       r_carry;

  logic [LANES*WIDTH-1:0] w_part;
  logic [WIDTH-1:0]       w_total;
  logic                   w_intra_ovf;
  logic [LANES*WIDTH-1:0] w_lane_sum;
  logic [LANES-1:0]       w_lane_ovf;
  logic [WIDTH-1:0]       w_carry_next;
  logic                   w_carry_ovf;
  logic                   w_s2_adv;
  logic                   w_s1_adv;
  logic                   w_accept;

  prefix_scan_comb #(
    .WIDTH    (WIDTH),
    .LANES    (LANES),
    .SATURATE (SATURATE)
  ) u_scan (
    .i_data  (IN_data),
    .o_part  (w_part),
    .o_total (w_total),
    .o_ovf   (w_intra_ovf)
  );

  assign w_s2_adv = !r_out_valid || OUT_ready;
  assign w_s1_adv = r_s1_valid && w_s2_adv;
  // Gated by rst_n so the port reads 0 while reset is held.
  assign IN_ready = rst_n && !IN_clear && (!r_s1_valid || w_s1_adv);
  assign w_accept = IN_valid && IN_ready;

  // Exclusive lane i takes the inclusive partial of lane i-1; lane 0 gets only the carry.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_sum;
    logic             w_ov;
    if (i == 0) begin : g_first
      assign w_base = (r_s1_mode == EXCL) ? '0 : r_s1_part[WIDTH-1:0];
    end else begin : g_rest
      assign w_base = (r_s1_mode == EXCL) ? r_s1_part[(i-1)*WIDTH +: WIDTH]
                                          : r_s1_part[i*WIDTH +: WIDTH];
    end
    always_comb begin
      w_sum = WIDTH'(sat_add(c_ADD_MAX_W'(r_carry), c_ADD_MAX_W'(w_base),
                             WIDTH, (SATURATE != 0), w_ov));
    end
    assign w_lane_sum[i*WIDTH +: WIDTH] = w_sum;
    assign w_lane_ovf[i]                = w_ov;
  end

  always_comb begin
    w_carry_next = WIDTH'(sat_add(c_ADD_MAX_W'(r_carry), c_ADD_MAX_W'(r_s1_total),
                                  WIDTH, (SATURATE != 0), w_carry_ovf));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_part  <= '0;
      r_s1_total <= '0;
      r_s1_ovf   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= INCL;
    end else if (IN_clear) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_part  <= w_part;
      r_s1_total <= w_total;
      r_s1_ovf   <= w_intra_ovf;
      r_s1_last  <= IN_last;
      r_s1_mode  <= scan_mode_e'(IN_excl);
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_carry     <= '0;
    end else if (IN_clear) begin
      r_out_valid <= 1'b0;
      r_carry     <= '0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_lane_sum;
      r_out_last  <= r_s1_last;
      r_out_ovf   <= r_s1_ovf || (|w_lane_ovf) || w_carry_ovf;
      r_carry     <= r_s1_last ? '0 : w_carry_next;
    end else if (w_s2_adv) begin
      r_out_valid <= 1'b0;
    end
  end

  assign OUT_valid = r_out_valid;
  assign OUT_data  = r_out_data;
  assign OUT_last  = r_out_last;
  assign OUT_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_prefix_scan_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_prefix_scan_pipe: directed bench, wrapping and saturating DUTs side by side
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_prefix_scan_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_excl;
  logic        in_clear;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_last, a_out_ovf;
  logic [31:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_out_last, b_out_ovf;
  logic [31:0] b_out_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prefix_scan_pipe #(.WIDTH(8), .LANES(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .IN_valid(in_valid), .IN_ready(a_in_ready), .IN_data(in_data),
    .IN_last(in_last), .IN_excl(in_excl), .IN_clear(in_clear),
    .OUT_valid(a_out_valid), .OUT_ready(out_ready), .OUT_data(a_out_data),
    .OUT_last(a_out_last), .OUT_ovf(a_out_ovf)
  );

  prefix_scan_pipe #(.WIDTH(8), .LANES(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .IN_valid(in_valid), .IN_ready(b_in_ready), .IN_data(in_data),
    .IN_last(in_last), .IN_excl(in_excl), .IN_clear(in_clear),
    .OUT_valid(b_out_valid), .OUT_ready(out_ready), .OUT_data(b_out_data),
    .OUT_last(b_out_last), .OUT_ovf(b_out_ovf)
  );

  function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic last, input logic excl);
    in_valid = v;
    in_data  = d;
    in_last  = last;
    in_excl  = excl;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] d, input logic last, input logic ovf);
    chk1({tag, "_valid"}, a_out_valid, 1'b1);
    chk ({tag, "_data"},  a_out_data,  d);
    chk1({tag, "_last"},  a_out_last,  last);
    chk1({tag, "_ovf"},   a_out_ovf,   ovf);
  endtask

  initial begin
    rst_n = 1'b0;
    in_clear = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick; tick;
    chk1("rst_out_valid", a_out_valid, 1'b0);
    chk ("rst_out_data",  a_out_data,  32'h0);
    chk1("rst_out_last",  a_out_last,  1'b0);
    chk1("rst_out_ovf",   a_out_ovf,   1'b0);
    chk1("rst_in_ready",  a_in_ready,  1'b0);
    rst_n = 1'b1;
    #1;
    chk1("rel_in_ready", a_in_ready, 1'b1);

    // Segment carry across beats, reset by last.
    tick;
    drive(1'b1, pk(1, 2, 3, 4), 1'b0, 1'b0);
    tick;
    drive(1'b1, pk(5, 5, 5, 5), 1'b1, 1'b0);
    chk1("seg_lat1", a_out_valid, 1'b0);
    tick;
    drive(1'b1, pk(1, 1, 1, 1), 1'b0, 1'b0);
    chk_a("seg_b0", pk(1, 3, 6, 10), 1'b0, 1'b0);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_a("seg_b1", pk(15, 20, 25, 30), 1'b1, 1'b0);
    tick;
    chk_a("seg_b2", pk(1, 2, 3, 4), 1'b0, 1'b0);
    tick;
    chk1("seg_drain", a_out_valid, 1'b0);

    // Clear leftover carry of 4 before the next test.
    in_clear = 1'b1;
    #1;
    chk1("clr_in_ready", a_in_ready, 1'b0);
    tick;
    in_clear = 1'b0;

    // Exclusive then inclusive in the same segment.
    drive(1'b1, pk(1, 2, 3, 4), 1'b0, 1'b1);
    tick;
    drive(1'b1, pk(1, 1, 1, 1), 1'b1, 1'b0);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_a("excl_b0", pk(0, 1, 3, 6), 1'b0, 1'b0);
    tick;
    chk_a("excl_b1", pk(11, 12, 13, 14), 1'b1, 1'b0);
    tick;

    // Intra-beat overflow, then carry-driven overflow.
    drive(1'b1, pk(200, 100, 0, 0), 1'b1, 1'b0);
    tick;
    drive(1'b1, pk(250, 0, 0, 0), 1'b0, 1'b0);
    tick;
    drive(1'b1, pk(10, 0, 0, 0), 1'b1, 1'b0);
    chk_a("ovf_wrap", pk(200, 44, 44, 44), 1'b1, 1'b1);
    chk ("ovf_sat_data", b_out_data, pk(200, 255, 255, 255));
    chk1("ovf_sat_flag", b_out_ovf, 1'b1);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_a("cov_wrap_b0", pk(250, 250, 250, 250), 1'b0, 1'b0);
    chk ("cov_sat_b0", b_out_data, pk(250, 250, 250, 250));
    tick;
    chk_a("cov_wrap_b1", pk(4, 4, 4, 4), 1'b1, 1'b1);
    chk ("cov_sat_b1", b_out_data, pk(255, 255, 255, 255));
    chk1("cov_sat_ovf", b_out_ovf, 1'b1);
    tick;

    // Backpressure: OUT_ready low for 4 cycles while 3 beats are offered.
    out_ready = 1'b0;
    drive(1'b1, pk(1, 0, 0, 0), 1'b0, 1'b0);
    tick;
    drive(1'b1, pk(2, 0, 0, 0), 1'b0, 1'b0);
    chk1("bp_rdy_b1", a_in_ready, 1'b1);
    tick;
    drive(1'b1, pk(3, 0, 0, 0), 1'b1, 1'b0);
    #1;
    chk1("bp_rdy_b2_c0", a_in_ready, 1'b0);
    chk_a("bp_hold0", pk(1, 1, 1, 1), 1'b0, 1'b0);
    tick;
    chk1("bp_rdy_b2_c1", a_in_ready, 1'b0);
    chk_a("bp_hold1", pk(1, 1, 1, 1), 1'b0, 1'b0);
    tick;
    chk_a("bp_hold2", pk(1, 1, 1, 1), 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk1("bp_rdy_release", a_in_ready, 1'b1);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_a("bp_out_b1", pk(3, 3, 3, 3), 1'b0, 1'b0);
    tick;
    chk_a("bp_out_b2", pk(6, 6, 6, 6), 1'b1, 1'b0);
    tick;
    chk1("bp_drain", a_out_valid, 1'b0);

    // Clear mid-stream with carry=10 and a beat waiting in S1.
    drive(1'b1, pk(1, 2, 3, 4), 1'b0, 1'b0);
    tick;
    drive(1'b1, pk(9, 9, 9, 9), 1'b0, 1'b0);
    tick;
    drive(1'b1, pk(7, 7, 7, 7), 1'b0, 1'b0);
    in_clear = 1'b1;
    #1;
    chk1("mclr_in_ready", a_in_ready, 1'b0);
    tick;
    in_clear = 1'b0;
    chk1("mclr_out_valid", a_out_valid, 1'b0);
    drive(1'b1, pk(1, 1, 1, 1), 1'b1, 1'b0);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk1("mclr_gap", a_out_valid, 1'b0);
    tick;
    chk_a("mclr_out", pk(1, 2, 3, 4), 1'b1, 1'b0);
    tick;

    // Asynchronous reset with both stages full.
    drive(1'b1, pk(1, 1, 1, 1), 1'b0, 1'b0);
    tick;
    drive(1'b1, pk(3, 3, 3, 3), 1'b0, 1'b0);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_out_valid", a_out_valid, 1'b0);
    chk ("arst_out_data",  a_out_data,  32'h0);
    chk1("arst_in_ready",  a_in_ready,  1'b0);
    tick; tick;
    rst_n = 1'b1;
    drive(1'b1, pk(2, 2, 2, 2), 1'b1, 1'b0);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk1("arst_no_ghost", a_out_valid, 1'b0);
    tick;
    chk_a("arst_out", pk(2, 4, 6, 8), 1'b1, 1'b0);
    tick;
    chk1("arst_drain", a_out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prefix_scan_pipe.md
PREFIX_SCAN_PIPE -- requirements
Module: prefix_scan_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: element width in bits, unsigned.
REQ-002 SHALL have parameter LANES, default 4: elements per beat, at least 1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 wraps modulo 2^WIDTH; 1 clamps at 2^WIDTH-1.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port IN_valid, input, 1 bit: input beat present.
REQ-007 SHALL have port IN_ready, output, 1 bit: input beat accepted when IN_valid and IN_ready are both high.
REQ-008 SHALL have port IN_data, input, LANES*WIDTH bits: lane i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port IN_last, input, 1 bit: beat ends the current segment.
REQ-010 SHALL have port IN_excl, input, 1 bit: per-beat select, 1 = exclusive scan, 0 = inclusive scan.
REQ-011 SHALL have port IN_clear, input, 1 bit: synchronous flush and carry clear.
REQ-012 SHALL have port OUT_valid, output, 1 bit: output beat present.
REQ-013 SHALL have port OUT_ready, input, 1 bit: output beat consumed when OUT_valid and OUT_ready are both high.
REQ-014 SHALL have port OUT_data, output, LANES*WIDTH bits: prefix results, same lane packing as IN_data.
REQ-015 SHALL have port OUT_last, output, 1 bit: IN_last of the corresponding beat.
REQ-016 SHALL have port OUT_ovf, output, 1 bit: an overflow occurred in any lane of this beat.

Function
REQ-017 SHALL compute, for an inclusive beat, lane i = carry + sum(in[0..i]); carry is the running total of prior beats in the segment.
REQ-018 SHALL compute, for an exclusive beat, lane 0 = carry and lane i = carry + sum(in[0..i-1]).
REQ-019 SHALL update carry to carry + sum(all lanes) on each beat transferred from S1 to S2, in both scan modes.
REQ-020 SHALL reset carry to 0 after transferring a beat with IN_last=1, so the next beat starts a new segment.
REQ-021 SHALL, with SATURATE=0, wrap every addition modulo 2^WIDTH.
REQ-022 SHALL, with SATURATE=1, clamp every partial sum and the carry at 2^WIDTH-1; a clamped value stays saturated to the end of the segment.
REQ-023 SHALL set OUT_ovf when any lane's true sum, or the new carry, exceeds 2^WIDTH-1; this applies in both modes.
REQ-024 SHALL use a two-stage pipeline:
- S1 registers the accepted beat and its intra-beat scan.
- S2 adds the carry and drives the OUT_* ports.
REQ-025 SHALL have a latency of 2 cycles from acceptance to OUT_valid when not stalled.
REQ-026 SHALL sustain a throughput of 1 beat per cycle while OUT_ready stays high.
REQ-027 SHALL advance S2 when !OUT_valid or OUT_ready; S1 advances when S1 is valid and S2 advances.
REQ-028 SHALL drive IN_ready = !s1_valid or s1_advance; a combinational path from OUT_ready to IN_ready is permitted.
REQ-029 SHALL hold OUT_data, OUT_last, OUT_ovf and OUT_valid stable while OUT_valid=1 and OUT_ready=0.
REQ-030 SHALL ensure no beat is lost, duplicated or reordered under any backpressure pattern.
REQ-031 SHALL, on IN_clear=1, clear s1_valid, s2_valid and carry at the next edge.
REQ-032 SHALL drive IN_ready=0 while IN_clear=1, so no beat is accepted in a clear cycle.
REQ-033 SHALL give IN_clear priority over any simultaneous accept, transfer or output handshake.
REQ-034 SHALL, with LANES=1, degenerate to a scalar running accumulator with the same timing.

Reset
REQ-035 SHALL, while rst_n=0, asynchronously force OUT_valid=0, OUT_data=0, OUT_last=0, OUT_ovf=0, carry=0, s1_valid=0 and IN_ready=0.
REQ-036 SHALL, on a reset assertion mid-stream, discard all in-flight beats and start after release with carry=0.
REQ-037 SHALL raise IN_ready in the first cycle after rst_n deasserts.

Structure
REQ-038 SHALL place the scan-mode enum (INCL, EXCL) and a saturating-add helper function in the shared package prefix_pkg.
REQ-039 SHALL implement the intra-beat scan as the combinational sub-module prefix_scan_comb.
- prefix_scan_comb takes WIDTH, LANES and SATURATE as parameters.
- prefix_scan_comb outputs per-lane partial sums, the beat total and an overflow flag.

Verification (WIDTH=8, LANES=4 unless stated)
REQ-040 SHALL cover segment carry:
- Stimulus: [1,2,3,4] last=0, then [5,5,5,5] last=1, then [1,1,1,1].
- Response: outputs [1,3,6,10], [15,20,25,30], [1,2,3,4], each 2 cycles after acceptance.
REQ-041 SHALL cover exclusive scan:
- Stimulus: [1,2,3,4] with excl=1, then [1,1,1,1] with excl=0.
- Response: [0,1,3,6], then [11,12,13,14].
REQ-042 SHALL cover overflow:
- Stimulus: [200,100,0,0].
- Response with SATURATE=0: [200,44,44,44], ovf=1.
- Response with SATURATE=1: [200,255,255,255], ovf=1.
REQ-043 SHALL cover backpressure:
- Stimulus: OUT_ready held 0 for 4 cycles while 3 beats are offered back-to-back.
- Response: 2 beats held, IN_ready=0 on the 3rd, OUT_data stable.
- Response on release: beats emerge in order, no loss or duplication.
REQ-044 SHALL cover clear mid-stream:
- Stimulus: carry=10 with one beat in S1; pulse IN_clear with IN_valid=1; then send [1,1,1,1].
- Response: clear beat not accepted, OUT_valid=0 next cycle, then [1,2,3,4].
REQ-045 SHALL cover reset mid-operation:
- Stimulus: assert rst_n=0 asynchronously between edges with S1 and S2 full.
- Response: immediate OUT_valid=0, OUT_data=0.
- Response after release: [2,2,2,2] yields [2,4,6,8].
